// File: rtl/lsb_pkg.sv
// Shared types and constants for the in-order load/store buffer.
package lsb_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  // Tag value meaning "operand already present"
  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  localparam logic OP_LOAD  = 1'b1;
  localparam logic OP_STORE = 1'b0;

  typedef struct packed {
    logic              valid;
    logic              op;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vk;
    logic [DATA_W-1:0] imm;
  } lsb_entry_t;

  // True when a pending operand tag is satisfied by the current CDB broadcast.
  function automatic logic tag_hit(input logic             cdb_valid,
                                   input logic [TAG_W-1:0] q,
                                   input logic [TAG_W-1:0] cdb_tag);
    return cdb_valid && (q != TAG_NONE) && (q == cdb_tag);
  endfunction

endpackage

// File: rtl/lsb_entry.sv
// One load/store buffer slot: holds an op and snoops the CDB for its
// pending base/store-data operands, both at write time and while waiting.
module lsb_entry
  import lsb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  lsb_entry_t        wr_data,
  input  logic              clr,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output lsb_entry_t        entry_o
);

  lsb_entry_t entry_q;
  lsb_entry_t entry_d;

  // Next state: new write (with same-cycle forwarding) or snoop on held contents, then dispatch clear
  always_comb begin
    entry_d = wr_en ? wr_data : entry_q;
    if (wr_en) begin
      entry_d.valid = 1'b1;
    end
    // The same capture rule covers an incoming op and a resident one
    if (entry_d.valid) begin
      if (tag_hit(cdb_valid, entry_d.qj, cdb_tag)) begin
        entry_d.vj = cdb_data;
        entry_d.qj = TAG_NONE;
      end
      if (tag_hit(cdb_valid, entry_d.qk, cdb_tag)) begin
        entry_d.vk = cdb_data;
        entry_d.qk = TAG_NONE;
      end
    end
    // A slot is never written and dispatched in the same cycle (full blocks issue),
    // but let the write win defensively.
    if (clr && !wr_en) begin
      entry_d.valid = 1'b0;
    end
  end

  // Slot register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store buffer sitting in front of the Memory unit.
// Circular FIFO of lsb_entry slots; only the head may dispatch, so program
// order is kept strictly and a stalled head blocks everything behind it.
module load_store_buffer
  import lsb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int TAG_BASE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              issue_op,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [DATA_W-1:0] issue_imm,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              mem_req,
  input  logic              mem_available,
  output logic              mem_op,
  output logic [DATA_W-1:0] mem_base,
  output logic [DATA_W-1:0] mem_offset,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [TAG_W-1:0]  mem_tag
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  lsb_entry_t entries [DEPTH];
  lsb_entry_t issue_entry;
  lsb_entry_t head_entry;
  logic       enq;
  logic       deq;

  // Full check uses registered count only, so a pop cannot make room in the same cycle
  assign issue_ready = (count_q != CNT_W'(DEPTH));
  assign issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(tail_q);
  assign enq         = issue_valid && issue_ready;

  assign issue_entry = '{valid: 1'b1, op: issue_op, qj: issue_qj, vj: issue_vj,
                         qk: issue_qk, vk: issue_vk, imm: issue_imm};

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
      lsb_entry u_entry (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (enq && (tail_q == IDX)),
        .wr_data   (issue_entry),
        .clr       (deq && (head_q == IDX)),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .entry_o   (entries[gi])
      );
    end
  endgenerate

  assign head_entry = entries[head_q];

  // Stores also need their data operand; loads ignore qk
  assign mem_req = head_entry.valid && (head_entry.qj == TAG_NONE) &&
                   ((head_entry.op == OP_LOAD) || (head_entry.qk == TAG_NONE));
  assign deq     = mem_req && mem_available;

  // Head fields go out unconditionally; they only change on dispatch or snoop of a pending head
  assign mem_op     = head_entry.op;
  assign mem_base   = head_entry.vj;
  assign mem_offset = head_entry.imm;
  assign mem_wdata  = head_entry.vk;
  assign mem_tag    = TAG_W'(TAG_BASE) + TAG_W'(head_q);

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    head_d  = head_q + PTR_W'(deq);
    tail_d  = tail_q + PTR_W'(enq);
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
